// File: rtl/uart_transmitter_if.sv
// rtl/uart_transmitter_if.sv - request handshake bundle for the UART transmitter
// Purpose: carries the byte-request handshake between a client and the transmitter.
// Signals:
//   tx_dv     request strobe, tx_data valid while high (client -> transmitter)
//   tx_data   byte to send, captured on accept        (client -> transmitter)
//   tx_ready  transmitter idle, request accepted only then (transmitter -> client)
// Modports: master = requesting client, slave = transmitter.
interface uart_transmitter_if;
  logic       tx_dv;
  logic [7:0] tx_data;
  logic       tx_ready;

  modport master (
    output tx_dv,
    output tx_data,
    input  tx_ready
  );

  modport slave (
    input  tx_dv,
    input  tx_data,
    output tx_ready
  );
endinterface

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - UART transmit serialiser, start + 8 data LSB-first + [parity] + stop
// Purpose: serialises one byte per accepted request onto an idle-high line; every bit
//   lasts CLKS_PER_BIT clocks. Optional even parity bit when UART_TX_PARITY_EN is defined.
// Ports:
//   clk        system clock, posedge
//   rst_n      asynchronous active-low reset
//   req        uart_transmitter_if.slave: tx_dv / tx_data in, tx_ready out
//   tx_serial  registered serial line, idle 1
//   tx_active  high from first START cycle through last STOP cycle
//   tx_done    one-cycle pulse in the CLEANUP cycle
// Parameters: CLKS_PER_BIT (>= 2), STOP_BITS (1 or 2).
// Configuration macro: UART_TX_PARITY_EN.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_transmitter_if.slave req,
  output logic              tx_serial,
  output logic              tx_active,
  output logic              tx_done
);

  localparam int               CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CLK_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY  = 3'd3,
`endif
    S_STOP    = 3'd4,
    S_CLEANUP = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  // Indexes the data bit in DATA and the stop bit in STOP.
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       data_q, data_d;
  logic             tx_serial_q, tx_serial_d;

  logic bit_end;
  assign bit_end = (clk_cnt_q == CLK_LAST);

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;

    case (state_q)
      S_IDLE: begin
        if (req.tx_dv) begin
          data_d    = req.tx_data;
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          state_d   = S_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = S_PARITY;
`else
            state_d   = S_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          state_d   = S_STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          if (bit_cnt_q == STOP_LAST) begin
            bit_cnt_d = '0;
            state_d   = S_CLEANUP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      S_CLEANUP: begin
        state_d = S_IDLE;
      end
      default: begin
        // Unreachable encodings fall back to a quiet idle line.
        state_d   = S_IDLE;
        clk_cnt_d = '0;
        bit_cnt_d = '0;
      end
    endcase

    // The line is registered, so it is decoded from the state being entered.
    case (state_d)
      S_START:  tx_serial_d = 1'b0;
      S_DATA:   tx_serial_d = data_q[bit_cnt_d];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_serial_d = ^data_q;
`endif
      default:  tx_serial_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      data_q      <= '0;
      tx_serial_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      data_q      <= data_d;
      tx_serial_q <= tx_serial_d;
    end
  end

  always_comb begin
    tx_active = 1'b0;
    case (state_q)
      S_START, S_DATA, S_STOP: tx_active = 1'b1;
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_active = 1'b1;
`endif
      default: tx_active = 1'b0;
    endcase
  end

  assign req.tx_ready = (state_q == S_IDLE);
  assign tx_done      = (state_q == S_CLEANUP);
  assign tx_serial    = tx_serial_q;

endmodule
